nonce_dispatcher: RTL and testbench

Work scheduler between the block storage and the hash cores. It captures each new 352-bit initial state presented by the block storage, then splits the 32-bit nonce space into fixed-size chunks and hands them out to NUM_CORES requesting cores under round-robin arbitration. It tracks exhaustion of the nonce space and aborts outstanding work on a new block or on a found result.

---
 rtl/nonce_dispatcher_if.sv | 33 +++
 rtl/nonce_dispatcher.sv | 118 +++++++++++
 tb/tb_nonce_dispatcher.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nonce_dispatcher_if.sv
// Handshake bundle between block storage / hash cores and the nonce dispatcher.
// The dispatcher uses the slave modport; block storage and cores drive through master.
interface nonce_dispatcher_if #(
    parameter int NUM_CORES = 4
);
    localparam int ID_W = $clog2(NUM_CORES);

    logic                 state_valid;
    logic                 new_block;
    logic [351:0]         initial_state;
    logic                 state_taken;
    logic [NUM_CORES-1:0] core_req;
    logic [NUM_CORES-1:0] core_found;
    logic [NUM_CORES-1:0] core_grant;
    logic [351:0]         work_state;
    logic [31:0]          work_nonce;
    logic                 work_abort;
    logic                 found_valid;
    logic [ID_W-1:0]      found_id;
    logic                 exhausted;

    modport master (
        output state_valid, new_block, initial_state, core_req, core_found,
        input  state_taken, core_grant, work_state, work_nonce, work_abort,
               found_valid, found_id, exhausted
    );

    modport slave (
        input  state_valid, new_block, initial_state, core_req, core_found,
        output state_taken, core_grant, work_state, work_nonce, work_abort,
               found_valid, found_id, exhausted
    );
endinterface

// File: rtl/nonce_dispatcher.sv
// Latches a block header and hands out fixed-size nonce chunks to requesting
// hash cores in round-robin order; aborts outstanding work on a new block or a find.
module nonce_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    nonce_dispatcher_if.slave    bus
);
    localparam int ID_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_EXHAUSTED} state_t;

    state_t               r_state;
    logic [31:0]          r_base;
    logic [ID_W-1:0]      r_last;
    logic [NUM_CORES-1:0] r_grant;
    logic [31:0]          r_nonce;
    logic [351:0]         r_work_state;
    logic                 r_state_taken;
    logic                 r_abort;
    logic                 r_found_valid;
    logic [ID_W-1:0]      r_found_id;
    logic                 r_exhausted;

    logic                 w_load;
    logic                 w_found_any;
    logic [ID_W-1:0]      w_found_idx;
    logic [NUM_CORES-1:0] w_eligible;
    logic [ID_W:0]        w_cand;
    logic                 w_win_valid;
    logic [ID_W-1:0]      w_win_idx;
    logic [32:0]          w_next_base;

    assign w_load      = bus.state_valid & bus.new_block;
    assign w_found_any = |bus.core_found;
    assign w_next_base = {1'b0, r_base} + (33'd1 << CHUNK_LOG2);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_found_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bus.core_found[i]) w_found_idx = ID_W'(i);
        end
    end

    // A core granted last cycle is skipped, so a held request waits at least one cycle.
    always_comb begin
        w_eligible  = bus.core_req & ~r_grant;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_cand = {1'b0, r_last} + (ID_W+1)'(k + 1);
            if (w_cand >= (ID_W+1)'(NUM_CORES)) w_cand = w_cand - (ID_W+1)'(NUM_CORES);
            if (!w_win_valid && w_eligible[w_cand[ID_W-1:0]]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand[ID_W-1:0];
            end
        end
    end

    // NOTE: state uses non-blocking assignments; pulse outputs default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_last        <= ID_W'(NUM_CORES - 1);
            r_grant       <= '0;
            r_nonce       <= '0;
            r_work_state  <= '0;
            r_state_taken <= 1'b0;
            r_abort       <= 1'b0;
            r_found_valid <= 1'b0;
            r_found_id    <= '0;
            r_exhausted   <= 1'b0;
        end else begin
            r_grant       <= '0;
            r_state_taken <= 1'b0;
            r_abort       <= 1'b0;
            r_found_valid <= 1'b0;
            r_exhausted   <= (r_state == S_EXHAUSTED);

            if (w_found_any && r_state != S_IDLE) begin
                r_found_valid <= 1'b1;
                r_found_id    <= w_found_idx;
                r_abort       <= 1'b1;
                r_state       <= S_IDLE;
                r_exhausted   <= 1'b0;
            end

            if (w_load) begin
                r_work_state  <= bus.initial_state;
                r_base        <= '0;
                r_state_taken <= 1'b1;
                r_state       <= S_DISPATCH;
                r_exhausted   <= 1'b0;
                if (r_state != S_IDLE) r_abort <= 1'b1;
            end else if (!w_found_any && r_state == S_DISPATCH && w_win_valid) begin
                r_grant <= NUM_CORES'(1) << w_win_idx;
                r_nonce <= r_base;
                r_last  <= w_win_idx;
                r_base  <= w_next_base[31:0];
                if (w_next_base[32]) r_state <= S_EXHAUSTED;
            end
        end
    end

    assign bus.core_grant  = r_grant;
    assign bus.work_nonce  = r_nonce;
    assign bus.work_state  = r_work_state;
    assign bus.state_taken = r_state_taken;
    assign bus.work_abort  = r_abort;
    assign bus.found_valid = r_found_valid;
    assign bus.found_id    = r_found_id;
    assign bus.exhausted   = r_exhausted;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: one instance with 256-nonce chunks and one
// with 2^30-nonce chunks to reach exhaustion quickly.
module tb_nonce_dispatcher;
    localparam logic [351:0] ST_A5 = {44{8'hA5}};
    localparam logic [351:0] ST_3C = {44{8'h3C}};
    localparam logic [351:0] ST_5A = {44{8'h5A}};

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    nonce_dispatcher_if #(.NUM_CORES(4)) bus8 ();
    nonce_dispatcher_if #(.NUM_CORES(4)) bus30 ();

    nonce_dispatcher #(.NUM_CORES(4), .CHUNK_LOG2(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    nonce_dispatcher #(.NUM_CORES(4), .CHUNK_LOG2(30)) u_dut30 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus30)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus8.state_valid  = 1'b0; bus8.new_block  = 1'b0; bus8.initial_state  = '0;
        bus8.core_req     = '0;   bus8.core_found = '0;
        bus30.state_valid = 1'b0; bus30.new_block = 1'b0; bus30.initial_state = '0;
        bus30.core_req    = '0;   bus30.core_found = '0;

        #2;
        check("rst_grant",  bus8.core_grant, '0);
        check("rst_nonce",  bus8.work_nonce, '0);
        check("rst_state",  bus8.work_state, '0);
        check("rst_taken",  bus8.state_taken, '0);
        check("rst_abort",  bus8.work_abort, '0);
        check("rst_found",  bus8.found_valid, '0);
        check("rst_exh",    bus8.exhausted, '0);
        #10;
        reset = 1'b0;
        tick();
        check("idle_no_grant", bus8.core_grant, '0);

        // Load A5 with core 0 holding its request.
        bus8.state_valid = 1'b1; bus8.new_block = 1'b1;
        bus8.initial_state = ST_A5; bus8.core_req = 4'b0001;
        tick();
        check("load_taken", bus8.state_taken, 1'b1);
        check("load_state", bus8.work_state, ST_A5);
        check("load_grant", bus8.core_grant, '0);
        check("load_abort", bus8.work_abort, 1'b0);
        bus8.state_valid = 1'b0; bus8.new_block = 1'b0;
        tick();
        check("taken_pulse", bus8.state_taken, 1'b0);
        check("g0_grant", bus8.core_grant, 4'b0001);
        check("g0_nonce", bus8.work_nonce, 32'h0);
        tick();
        check("g0_gap", bus8.core_grant, '0);
        tick();
        check("g1_grant", bus8.core_grant, 4'b0001);
        check("g1_nonce", bus8.work_nonce, 32'h100);
        tick();
        check("g1_gap", bus8.core_grant, '0);
        tick();
        check("g2_grant", bus8.core_grant, 4'b0001);
        check("g2_nonce", bus8.work_nonce, 32'h200);
        check("g2_state", bus8.work_state, ST_A5);

        // All four cores requesting: round-robin continues after core 0.
        bus8.core_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int core;
            core = (i + 1) % 4;
            tick();
            check("rr_grant", bus8.core_grant, 4'b0001 << core);
            check("rr_nonce", bus8.work_nonce, 32'h300 + 32'(i) * 32'h100);
            check("rr_onehot", $onehot0(bus8.core_grant), 1'b1);
        end

        // Found from cores 1 and 2: lowest index reported, abort, back to idle.
        bus8.core_found = 4'b0110;
        tick();
        check("fnd_valid", bus8.found_valid, 1'b1);
        check("fnd_id",    bus8.found_id, 2'd1);
        check("fnd_abort", bus8.work_abort, 1'b1);
        check("fnd_grant", bus8.core_grant, '0);
        bus8.core_found = '0;
        tick();
        check("fnd_vpulse", bus8.found_valid, 1'b0);
        check("fnd_apulse", bus8.work_abort, 1'b0);
        check("idle_req_ignored", bus8.core_grant, '0);
        bus8.core_found = 4'b0001;
        tick();
        check("idle_found_ignored", bus8.found_valid, 1'b0);
        check("idle_no_abort", bus8.work_abort, 1'b0);
        check("idle_grant2", bus8.core_grant, '0);
        bus8.core_found = '0;

        // Load from idle, then load and found[3] together while dispatching.
        bus8.core_req = '0;
        bus8.state_valid = 1'b1; bus8.new_block = 1'b1; bus8.initial_state = ST_3C;
        tick();
        check("ld3c_taken", bus8.state_taken, 1'b1);
        check("ld3c_abort", bus8.work_abort, 1'b0);
        check("ld3c_state", bus8.work_state, ST_3C);
        bus8.state_valid = 1'b0; bus8.new_block = 1'b0;
        tick();
        bus8.state_valid = 1'b1; bus8.new_block = 1'b1; bus8.initial_state = ST_5A;
        bus8.core_found = 4'b1000;
        tick();
        check("lf_valid", bus8.found_valid, 1'b1);
        check("lf_id",    bus8.found_id, 2'd3);
        check("lf_abort", bus8.work_abort, 1'b1);
        check("lf_taken", bus8.state_taken, 1'b1);
        check("lf_state", bus8.work_state, ST_5A);
        check("lf_grant", bus8.core_grant, '0);
        bus8.state_valid = 1'b0; bus8.new_block = 1'b0; bus8.core_found = '0;
        bus8.core_req = 4'b0100;
        tick();
        check("lf_single_abort", bus8.work_abort, 1'b0);
        check("lf_next_grant", bus8.core_grant, 4'b0100);
        check("lf_next_nonce", bus8.work_nonce, 32'h0);
        tick();
        check("lf_gap", bus8.core_grant, '0);
        tick();
        check("pre_rst_grant", bus8.core_grant, 4'b0100);
        check("pre_rst_nonce", bus8.work_nonce, 32'h100);

        // Asynchronous reset mid-job.
        reset = 1'b1;
        #1;
        check("arst_grant", bus8.core_grant, '0);
        check("arst_nonce", bus8.work_nonce, '0);
        check("arst_state", bus8.work_state, '0);
        check("arst_id",    bus8.found_id, '0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_grant", bus8.core_grant, '0);
        check("post_rst_abort", bus8.work_abort, 1'b0);
        check("post_rst_found", bus8.found_valid, 1'b0);
        bus8.core_req = 4'b1111;
        bus8.state_valid = 1'b1; bus8.new_block = 1'b1; bus8.initial_state = ST_A5;
        tick();
        check("reld_taken", bus8.state_taken, 1'b1);
        bus8.state_valid = 1'b0; bus8.new_block = 1'b0;
        tick();
        check("reld_rr_core0", bus8.core_grant, 4'b0001);
        check("reld_nonce", bus8.work_nonce, 32'h0);
        bus8.core_req = '0;

        // Exhaustion with 2^30-nonce chunks, single core.
        bus30.state_valid = 1'b1; bus30.new_block = 1'b1;
        bus30.initial_state = ST_A5; bus30.core_req = 4'b0001;
        tick();
        check("x_taken", bus30.state_taken, 1'b1);
        bus30.state_valid = 1'b0; bus30.new_block = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("x_grant", bus30.core_grant, 4'b0001);
            check("x_nonce", bus30.work_nonce, 32'(g) << 30);
            check("x_not_exh", bus30.exhausted, 1'b0);
            if (g < 3) begin
                tick();
                check("x_gap", bus30.core_grant, '0);
            end
        end
        tick();
        check("x_exh", bus30.exhausted, 1'b1);
        check("x_exh_grant", bus30.core_grant, '0);
        tick();
        check("x_exh_hold", bus30.exhausted, 1'b1);
        check("x_exh_grant2", bus30.core_grant, '0);
        bus30.state_valid = 1'b1; bus30.new_block = 1'b1; bus30.initial_state = ST_3C;
        tick();
        check("x_reld_exh", bus30.exhausted, 1'b0);
        check("x_reld_taken", bus30.state_taken, 1'b1);
        check("x_reld_abort", bus30.work_abort, 1'b1);
        check("x_reld_state", bus30.work_state, ST_3C);
        bus30.state_valid = 1'b0; bus30.new_block = 1'b0;
        tick();
        check("x_restart_grant", bus30.core_grant, 4'b0001);
        check("x_restart_nonce", bus30.work_nonce, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
